ram_port_arbiter: RTL and testbench

Arbitrates the single-port RAM between two requesters: the CPU (controller/datapath memory port) and the host loader (prepopulation/debug port). It replaces the static wrIn-steered muxing with a registered request/grant scheduler. Each granted access is sequenced onto the RAM's rd/wr/address/data pins, and read data is returned with a per-port valid pulse. A host lock lets the loader burst-fill memory while CPU accesses are held off.

---
 rtl/ram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin scheduler sharing one RAM port
// between the CPU datapath and the host loader, with host lock.
module ram_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [WIDTH-1:0]  host_rdata,
  output logic              host_rvalid,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [WIDTH-1:0]  ram_rdata,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    CAPTURE
  } state_t;

  // WAIT spans RD_LAT-1 cycles: count RD_LAT-2 down to zero.
  localparam logic [1:0] WAIT_LOAD =
    (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
  localparam bit NEEDS_WAIT = (RD_LAT > 1);

  state_t state;
  state_t nextState;

  logic              cpuOk;
  logic              hostOk;
  logic              anyOk;
  logic              pickHost;
  logic              lastHost;
  logic              curHost;
  logic              curWe;
  logic [AWIDTH-1:0] curAddr;
  logic [WIDTH-1:0]  curWdata;
  logic [1:0]        waitCnt;

  // Eligibility and round-robin pick; lastHost favours the other port.
  always_comb begin
    cpuOk    = cpu_req & ~host_lock;
    hostOk   = host_req;
    anyOk    = cpuOk | hostOk;
    pickHost = hostOk & (~cpuOk | ~lastHost);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: reads skip WAIT entirely when RAM answers in one cycle.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (anyOk) nextState = ACCESS;
      end
      ACCESS: begin
        if (curWe) begin
          nextState = IDLE;
        end else if (NEEDS_WAIT) begin
          nextState = WAIT;
        end else begin
          nextState = CAPTURE;
        end
      end
      WAIT: begin
        if (waitCnt == 2'd0) nextState = CAPTURE;
      end
      CAPTURE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Latch the winner's command once; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastHost <= 1'b1;
      curHost  <= 1'b0;
      curWe    <= 1'b0;
      curAddr  <= '0;
      curWdata <= '0;
    end else if (state == IDLE && anyOk) begin
      lastHost <= pickHost;
      curHost  <= pickHost;
      curWe    <= pickHost ? host_we : cpu_we;
      curAddr  <= pickHost ? host_addr : cpu_addr;
      curWdata <= pickHost ? host_wdata : cpu_wdata;
    end
  end

  // Read-latency down-counter, loaded as the read strobe goes out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt <= 2'd0;
    end else if (state == ACCESS) begin
      waitCnt <= WAIT_LOAD;
    end else if (state == WAIT && waitCnt != 2'd0) begin
      waitCnt <= waitCnt - 2'd1;
    end
  end

  // Return read data to the owning port with a one-cycle valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata   <= '0;
      host_rdata  <= '0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      if (state == CAPTURE) begin
        if (curHost) begin
          host_rdata  <= ram_rdata;
          host_rvalid <= 1'b1;
        end else begin
          cpu_rdata  <= ram_rdata;
          cpu_rvalid <= 1'b1;
        end
      end
    end
  end

  // Outputs decoded from registered state and latched command only.
  always_comb begin
    cpu_gnt      = (state == ACCESS) & ~curHost;
    host_gnt     = (state == ACCESS) & curHost;
    ram_rd       = (state == ACCESS) & ~curWe;
    ram_wr       = (state == ACCESS) & curWe;
    ram_wdata_oe = (state == ACCESS) & curWe;
    ram_addr     = curAddr;
    ram_wdata    = curWdata;
    arb_busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: two DUTs (RD_LAT 1 and 3) driven by randomized
// handshaking requesters, checked each cycle against a timeline model.
module tb_ram_port_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  typedef enum int {
    M_IDLE,
    M_BOTH,
    M_LOCK,
    M_RAND,
    M_CPURD,
    M_ONE
  } mode_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hostLock = 1'b0;

  always #5 clk = ~clk;

  logic         cpuReq[N], cpuWe[N], hostReq[N], hostWe[N];
  logic [W-1:0] cpuAddr[N], cpuWdata[N], hostAddr[N], hostWdata[N];
  logic         cpuGnt[N], hostGnt[N], cpuRvalid[N], hostRvalid[N];
  logic         ramRd[N], ramWr[N], ramOe[N], busy[N];
  logic [W-1:0] cpuRdata[N], hostRdata[N];
  logic [W-1:0] ramAddr[N], ramWdata[N], ramRdata[N];

  function automatic logic [W-1:0] memInit(input int a);
    if (a == 16) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + W'(a) * 32'h0000_0101;
  endfunction

  function automatic int latOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < N; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [W-1:0] mem[32];
    logic [W-1:0] pipe[4];
    bit loaded = 1'b0;

    ram_port_arbiter #(.WIDTH(W), .AWIDTH(W), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpuReq[g]), .cpu_we(cpuWe[g]),
      .cpu_addr(cpuAddr[g]), .cpu_wdata(cpuWdata[g]),
      .cpu_gnt(cpuGnt[g]), .cpu_rdata(cpuRdata[g]),
      .cpu_rvalid(cpuRvalid[g]),
      .host_req(hostReq[g]), .host_we(hostWe[g]),
      .host_addr(hostAddr[g]), .host_wdata(hostWdata[g]),
      .host_lock(hostLock), .host_gnt(hostGnt[g]),
      .host_rdata(hostRdata[g]), .host_rvalid(hostRvalid[g]),
      .ram_rd(ramRd[g]), .ram_wr(ramWr[g]),
      .ram_addr(ramAddr[g]), .ram_wdata(ramWdata[g]),
      .ram_wdata_oe(ramOe[g]), .ram_rdata(ramRdata[g]),
      .arb_busy(busy[g])
    );

    assign ramRdata[g] = pipe[LAT-1];

    // RAM with LAT-cycle read pipeline; junk on the bus when not reading.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int a = 0; a < 32; a++) mem[a] <= memInit(a);
        loaded <= 1'b1;
      end else if (ramWr[g]) begin
        mem[ramAddr[g][4:0]] <= ramWdata[g];
      end
      pipe[0] <= ramRd[g] ? mem[ramAddr[g][4:0]] : W'($urandom);
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end
  end

  // Reference model state: one access in flight, timed by arithmetic.
  int           timer[N], len[N];
  bit           lastHost[N], accHost[N], accWe[N];
  logic [W-1:0] accAddr[N], accWdata[N], accData[N];
  logic [W-1:0] modelMem[N][32];
  bit           memLoaded = 1'b0;
  logic         eCpuGnt[N], eHostGnt[N], eRd[N], eWr[N], eOe[N], eBusy[N];
  logic         eCpuRv[N], eHostRv[N], eChkAddr[N], eChkWd[N];
  logic [W-1:0] eAddr[N], eWdata[N], heldCpu[N], heldHost[N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int t, l, k;
      bit h, we, lh, cOk, hOk;
      logic [W-1:0] ad, wd, rv;
      t = timer[i]; l = len[i]; h = accHost[i]; we = accWe[i];
      lh = lastHost[i]; ad = accAddr[i]; wd = accWdata[i];
      rv = accData[i];
      eCpuGnt[i] <= 1'b0; eHostGnt[i] <= 1'b0;
      eRd[i] <= 1'b0; eWr[i] <= 1'b0; eOe[i] <= 1'b0;
      eBusy[i] <= 1'b0; eCpuRv[i] <= 1'b0; eHostRv[i] <= 1'b0;
      eChkAddr[i] <= 1'b0; eChkWd[i] <= 1'b0;
      eAddr[i] <= ad; eWdata[i] <= wd;
      if (reset) begin
        if (!memLoaded)
          for (int a = 0; a < 32; a++) modelMem[i][a] <= memInit(a);
        t = 0; lh = 1'b1; ad = '0; wd = '0;
        heldCpu[i] <= '0; heldHost[i] <= '0;
        eChkAddr[i] <= 1'b1; eChkWd[i] <= 1'b1;
        eAddr[i] <= '0; eWdata[i] <= '0;
      end else begin
        if (t > 0) t--;
        if (t == 0) begin
          cOk = cpuReq[i] && !hostLock;
          hOk = hostReq[i];
          if (cOk || hOk) begin
            h  = hOk && (!cOk || !lh);
            lh = h;
            we = h ? hostWe[i] : cpuWe[i];
            ad = h ? hostAddr[i] : cpuAddr[i];
            wd = h ? hostWdata[i] : cpuWdata[i];
            if (we) modelMem[i][ad[4:0]] <= wd;
            else    rv = modelMem[i][ad[4:0]];
            l = we ? 2 : latOf(i) + 2;
            t = l;
          end
        end
        if (t > 0) begin
          k = l - t;
          if (k <= l - 2) begin
            eBusy[i] <= 1'b1; eChkAddr[i] <= 1'b1; eAddr[i] <= ad;
          end
          if (k == 0) begin
            eCpuGnt[i] <= !h; eHostGnt[i] <= h;
            eRd[i] <= !we; eWr[i] <= we; eOe[i] <= we;
            eChkWd[i] <= we; eWdata[i] <= wd;
          end
          if (!we && k == l - 1) begin
            if (h) begin eHostRv[i] <= 1'b1; heldHost[i] <= rv; end
            else   begin eCpuRv[i] <= 1'b1; heldCpu[i] <= rv; end
          end
        end
      end
      timer[i] <= t; len[i] <= l; accHost[i] <= h; accWe[i] <= we;
      lastHost[i] <= lh; accAddr[i] <= ad; accWdata[i] <= wd;
      accData[i] <= rv;
    end
    memLoaded <= 1'b1;
  end

  int    tests = 0;
  int    fails = 0;
  mode_t mode = M_IDLE;
  bit    done[N];
  logic         dirWe;
  logic [W-1:0] dirAddr, dirData;

  task automatic checkEq(input string tag, input int i,
                         input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %h expected %h", tag, i, got, exp);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < N; i++) begin
      checkEq("cpu_gnt", i, W'(cpuGnt[i]), W'(eCpuGnt[i]));
      checkEq("host_gnt", i, W'(hostGnt[i]), W'(eHostGnt[i]));
      checkEq("ram_rd", i, W'(ramRd[i]), W'(eRd[i]));
      checkEq("ram_wr", i, W'(ramWr[i]), W'(eWr[i]));
      checkEq("wdata_oe", i, W'(ramOe[i]), W'(eOe[i]));
      checkEq("arb_busy", i, W'(busy[i]), W'(eBusy[i]));
      checkEq("cpu_rvalid", i, W'(cpuRvalid[i]), W'(eCpuRv[i]));
      checkEq("host_rvalid", i, W'(hostRvalid[i]), W'(eHostRv[i]));
      checkEq("cpu_rdata", i, cpuRdata[i], heldCpu[i]);
      checkEq("host_rdata", i, hostRdata[i], heldHost[i]);
      checkEq("rd_wr_excl", i, W'(ramRd[i] & ramWr[i]), '0);
      checkEq("gnt_excl", i, W'(cpuGnt[i] & hostGnt[i]), '0);
      if (eChkAddr[i]) checkEq("ram_addr", i, ramAddr[i], eAddr[i]);
      if (eChkWd[i]) checkEq("ram_wdata", i, ramWdata[i], eWdata[i]);
    end
  endtask

  task automatic portCmd(input bit isHost, input bit gnt, input bit dn,
                         inout logic req, inout logic we,
                         inout logic [W-1:0] addr, inout logic [W-1:0] data);
    if (req && !gnt) return;
    req = 1'b0;
    case (mode)
      M_BOTH, M_LOCK: begin
        req = 1'b1; we = 1'b1; addr = $urandom; data = $urandom;
      end
      M_RAND: begin
        req  = ($urandom_range(0, 2) != 0);
        we   = 1'($urandom_range(0, 1));
        addr = $urandom; data = $urandom;
      end
      M_CPURD: if (!isHost) begin
        req = 1'b1; we = 1'b0; addr = $urandom; data = $urandom;
      end
      M_ONE: if (!isHost && !dn) begin
        req = 1'b1; we = dirWe; addr = dirAddr; data = dirData;
      end
      default: ;
    endcase
  endtask

  task automatic drive();
    if (mode == M_RAND && $urandom_range(0, 15) == 0) hostLock = ~hostLock;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        cpuReq[i] = 1'b0; hostReq[i] = 1'b0;
      end else begin
        if (cpuReq[i] && cpuGnt[i]) done[i] = 1'b1;
        portCmd(1'b0, cpuGnt[i], done[i],
                cpuReq[i], cpuWe[i], cpuAddr[i], cpuWdata[i]);
        portCmd(1'b1, hostGnt[i], 1'b1,
                hostReq[i], hostWe[i], hostAddr[i], hostWdata[i]);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkAll();
    drive();
  endtask

  task automatic runMode(input mode_t m, input int n);
    mode = m;
    repeat (n) cycle();
  endtask

  task automatic oneShot(input logic we, input logic [W-1:0] a,
                         input logic [W-1:0] d);
    dirWe = we; dirAddr = a; dirData = d;
    for (int i = 0; i < N; i++) done[i] = 1'b0;
    mode = M_ONE;
    for (int n = 0; n < 40 && !(done[0] && done[1]); n++) cycle();
    checkEq("oneshot_done", 0, W'(done[0] && done[1]), W'(1));
    runMode(M_IDLE, 8);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    runMode(M_IDLE, 2);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cpuReq[i] = 1'b0; cpuWe[i] = 1'b0; cpuAddr[i] = '0;
      cpuWdata[i] = '0; hostReq[i] = 1'b0; hostWe[i] = 1'b0;
      hostAddr[i] = '0; hostWdata[i] = '0; done[i] = 1'b0;
    end
    dirWe = 1'b0; dirAddr = '0; dirData = '0;
    runMode(M_IDLE, 3);
    reset = 1'b0;
    runMode(M_IDLE, 3);
    oneShot(1'b0, 32'h10, '0);
    oneShot(1'b1, 32'h10, 32'hA5A5_A5A5);
    oneShot(1'b0, 32'h10, '0);
    pulseReset();
    runMode(M_BOTH, 20);
    hostLock = 1'b1;
    runMode(M_LOCK, 20);
    hostLock = 1'b0;
    runMode(M_BOTH, 10);
    runMode(M_CPURD, 9);
    hostLock = 1'b1;
    runMode(M_LOCK, 16);
    hostLock = 1'b0;
    runMode(M_IDLE, 12);
    runMode(M_RAND, 3000);
    hostLock = 1'b0;
    runMode(M_IDLE, 12);
    mode = M_CPURD;
    for (int n = 0; n < 40 && !ramRd[0]; n++) cycle();
    checkEq("rd_seen", 0, W'(ramRd[0]), W'(1));
    #1 reset = 1'b1;
    #1;
    checkEq("async_rd_drop", 0, W'(ramRd[0]), '0);
    checkEq("async_busy_drop", 0, W'(busy[0]), '0);
    runMode(M_IDLE, 2);
    reset = 1'b0;
    runMode(M_IDLE, 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
